// File: rtl/fifo_wr_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_ctrl_if
// Write-side signal bundle for the dual-clock gray-pointer FIFO.
//
// Parameter:
//   ADDR_W       memory address width; the pointer width is ADDR_W+1
//
// Signals:
//   w_inc        write request from the producer
//   sync_rd_ptr  gray read pointer, already synchronised into the write clock
//   w_en         memory write strobe
//   w_addr       binary write address
//   gray_w_ptr   registered gray write pointer for the read-domain synchroniser
//   full         registered full flag
//   almost_full  registered almost-full flag
//   w_level      registered fill level
//   w_ovf        sticky overflow flag       (only with FIFO_WR_OVF_EN)
//   w_drop_cnt   saturating drop counter    (only with FIFO_WR_OVF_EN)
//
// Modports:
//   master  producer side (drives w_inc and sync_rd_ptr)
//   slave   controller side (fifo_wr_ctrl)
// ----------------------------------------------------------------------------
interface fifo_wr_ctrl_if #(
   parameter int ADDR_W = 4
);
   logic              w_inc;
   logic [ADDR_W:0]   sync_rd_ptr;
   logic              w_en;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W:0]   gray_w_ptr;
   logic              full;
   logic              almost_full;
   logic [ADDR_W:0]   w_level;
`ifdef FIFO_WR_OVF_EN
   logic              w_ovf;
   logic [7:0]        w_drop_cnt;

   modport master (
      output w_inc, sync_rd_ptr,
      input  w_en, w_addr, gray_w_ptr, full, almost_full, w_level,
             w_ovf, w_drop_cnt
   );

   modport slave (
      input  w_inc, sync_rd_ptr,
      output w_en, w_addr, gray_w_ptr, full, almost_full, w_level,
             w_ovf, w_drop_cnt
   );
`else
   modport master (
      output w_inc, sync_rd_ptr,
      input  w_en, w_addr, gray_w_ptr, full, almost_full, w_level
   );

   modport slave (
      input  w_inc, sync_rd_ptr,
      output w_en, w_addr, gray_w_ptr, full, almost_full, w_level
   );
`endif
endinterface

// File: rtl/fifo_wr_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller for the dual-clock gray-pointer FIFO. Keeps the binary
// write pointer, publishes a registered gray copy of it for the read domain,
// and derives registered full / almost_full / fill-level flags from the gray
// read pointer that has already been synchronised into w_clk.
//
// Parameters:
//   ADDR_W        memory address width, depth = 2**ADDR_W (legal 2..12)
//   AFULL_THRESH  fill level at or above which almost_full asserts
//                 (legal 1..2**ADDR_W)
//
// Ports:
//   w_clk   write-domain clock
//   w_rst   asynchronous, active-high reset
//   wr      fifo_wr_ctrl_if.slave bundle (w_inc, sync_rd_ptr in;
//           w_en, w_addr, gray_w_ptr, full, almost_full, w_level out)
//
// Optional feature macro: FIFO_WR_OVF_EN
//   When defined, the bundle also carries w_ovf (sticky, set by the first
//   write attempted while full) and w_drop_cnt (dropped writes, saturating
//   at 255). When undefined, dropped writes are silently ignored and no
//   counter logic exists.
// ----------------------------------------------------------------------------
module fifo_wr_ctrl #(
   parameter int ADDR_W       = 4,
   parameter int AFULL_THRESH = 14
) (
   input  logic            w_clk,
   input  logic            w_rst,
   fifo_wr_ctrl_if.slave   wr
);

   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] AFULL_VAL = PW'(AFULL_THRESH);

   logic [PW-1:0] w_bin;
   logic [PW-1:0] w_bin_nxt;
   logic [PW-1:0] w_gray_nxt;
   logic [PW-1:0] gray_q;
   logic [PW-1:0] r_bin;
   logic [PW-1:0] full_match;
   logic [PW-1:0] level_nxt;
   logic          full_q;
   logic          afull_q;
   logic [PW-1:0] level_q;
   logic          w_en;

   // A write is taken only while the FIFO is not full; the strobe is
   // combinational so the memory sees it in the same cycle as the request.
   assign w_en = wr.w_inc & ~full_q;

   // Next-pointer arithmetic. The binary pointer wraps naturally modulo
   // 2**PW, and the gray code is derived from the *next* binary value so the
   // gray register moves on the same edge as the binary one.
   always_comb begin
      w_bin_nxt  = w_bin + PW'(w_en);
      w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
   end

   // Gray-to-binary decode of the synchronised read pointer: each binary bit
   // is the XOR of all gray bits at or above it. Shifting right and reducing
   // avoids a bit-by-bit self-referencing chain.
   always_comb begin
      r_bin = '0;
      for (int i = 0; i < PW; i++) begin
         r_bin[i] = ^(wr.sync_rd_ptr >> i);
      end
   end

   // The FIFO is full when the write pointer has lapped the read pointer
   // exactly once: in gray code that means the two MSBs differ and the rest
   // match. Level uses the next binary pointer so full, almost_full and
   // level all agree on the edge that fills the last slot. Because the read
   // pointer lags, these values can only overstate occupancy.
   always_comb begin
      full_match = {~wr.sync_rd_ptr[ADDR_W:ADDR_W-1], wr.sync_rd_ptr[ADDR_W-2:0]};
      level_nxt  = w_bin_nxt - r_bin;
   end

   // Pointer and flag registers, all cleared asynchronously by w_rst.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         w_bin   <= '0;
         gray_q  <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         level_q <= '0;
      end else begin
         w_bin   <= w_bin_nxt;
         gray_q  <= w_gray_nxt;
         full_q  <= (w_gray_nxt == full_match);
         afull_q <= (level_nxt >= AFULL_VAL);
         level_q <= level_nxt;
      end
   end

   assign wr.w_en        = w_en;
   assign wr.w_addr      = w_bin[ADDR_W-1:0];
   assign wr.gray_w_ptr  = gray_q;
   assign wr.full        = full_q;
   assign wr.almost_full = afull_q;
   assign wr.w_level     = level_q;

`ifdef FIFO_WR_OVF_EN
   logic       drop;
   logic       ovf_q;
   logic [7:0] drop_cnt_q;

   assign drop = wr.w_inc & full_q;

   // Overflow bookkeeping: the flag is sticky until reset, and the counter
   // stops at its maximum instead of wrapping back to a misleading small value.
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) begin
               drop_cnt_q <= drop_cnt_q + 8'd1;
            end
         end
      end
   end

   assign wr.w_ovf      = ovf_q;
   assign wr.w_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Self-checking bench for fifo_wr_ctrl. Two instances are exercised: one with
// ADDR_W=4 / AFULL_THRESH=14 and one with ADDR_W=6 / AFULL_THRESH=60. Every
// cycle the expected register contents are predicted from an occupancy model
// (write and read counts) and queued; after the clock edge the entry is
// popped and compared with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

   typedef struct {
      int addr;
      int gray;
      int full;
      int afull;
      int level;
      int flips;
      int ovf;
      int drops;
   } exp_t;

   logic w_clk;
   logic w_rst;

   fifo_wr_ctrl_if #(.ADDR_W(4)) if4 ();
   fifo_wr_ctrl_if #(.ADDR_W(6)) if6 ();

   fifo_wr_ctrl #(.ADDR_W(4), .AFULL_THRESH(14)) dut4 (
      .w_clk (w_clk),
      .w_rst (w_rst),
      .wr    (if4.slave)
   );

   fifo_wr_ctrl #(.ADDR_W(6), .AFULL_THRESH(60)) dut6 (
      .w_clk (w_clk),
      .w_rst (w_rst),
      .wr    (if6.slave)
   );

   int   checks;
   int   failures;
   exp_t sb[$];

   int m_w;
   int m_full;
   int m_ovf;
   int m_drops;
   int prev_gray;

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int gray_of(int b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Snapshot of the selected instance's outputs, zero-extended to int.
   task automatic observe(input bit use6, output int addr, output int gray,
                          output int full, output int afull, output int level,
                          output int en, output int ovf, output int drops);
      ovf   = 0;
      drops = 0;
      if (use6) begin
         addr  = int'(if6.w_addr);
         gray  = int'(if6.gray_w_ptr);
         full  = int'(if6.full);
         afull = int'(if6.almost_full);
         level = int'(if6.w_level);
         en    = int'(if6.w_en);
`ifdef FIFO_WR_OVF_EN
         ovf   = int'(if6.w_ovf);
         drops = int'(if6.w_drop_cnt);
`endif
      end else begin
         addr  = int'(if4.w_addr);
         gray  = int'(if4.gray_w_ptr);
         full  = int'(if4.full);
         afull = int'(if4.almost_full);
         level = int'(if4.w_level);
         en    = int'(if4.w_en);
`ifdef FIFO_WR_OVF_EN
         ovf   = int'(if4.w_ovf);
         drops = int'(if4.w_drop_cnt);
`endif
      end
   endtask

   task automatic model_reset();
      m_w       = 0;
      m_full    = 0;
      m_ovf     = 0;
      m_drops   = 0;
      prev_gray = 0;
   endtask

   task automatic check_reset(input bit use6, input string tag);
      int a, g, f, af, l, e, o, d;
      observe(use6, a, g, f, af, l, e, o, d);
      check({tag, "_addr"},  a,  0);
      check({tag, "_gray"},  g,  0);
      check({tag, "_full"},  f,  0);
      check({tag, "_afull"}, af, 0);
      check({tag, "_level"}, l,  0);
`ifdef FIFO_WR_OVF_EN
      check({tag, "_ovf"},   o,  0);
      check({tag, "_drops"}, d,  0);
`endif
   endtask

   // Drive one cycle of stimulus, check the combinational strobe and current
   // address, and queue the expected post-edge state.
   task automatic apply_stimulus(input bit use6, input bit inc, input int rd_bin);
      int   depth, modp, thresh, accept, drop, nxt, lvl;
      int   a, g, f, af, l, e, o, d;
      exp_t x;
      depth  = use6 ? 64 : 16;
      thresh = use6 ? 60 : 14;
      modp   = 2 * depth;
      if (use6) begin
         if6.w_inc       = inc;
         if6.sync_rd_ptr = 7'(gray_of(rd_bin % modp));
      end else begin
         if4.w_inc       = inc;
         if4.sync_rd_ptr = 5'(gray_of(rd_bin % modp));
      end
      #1;
      accept = (inc && !m_full) ? 1 : 0;
      drop   = (inc && m_full) ? 1 : 0;
      observe(use6, a, g, f, af, l, e, o, d);
      check("w_en", e, accept);
      check("w_addr_pre", a, m_w % depth);

      nxt = (m_w + accept) % modp;
      lvl = ((nxt - (rd_bin % modp)) % modp + modp) % modp;
      x.addr  = nxt % depth;
      x.gray  = gray_of(nxt);
      x.level = lvl;
      x.full  = (lvl == depth) ? 1 : 0;
      x.afull = (lvl >= thresh) ? 1 : 0;
      x.flips = accept;
      if (drop != 0) begin
         m_ovf = 1;
         if (m_drops < 255) m_drops++;
      end
      x.ovf   = m_ovf;
      x.drops = m_drops;
      sb.push_back(x);

      m_w    = nxt;
      m_full = x.full;
   endtask

   // Wait for the edge, then pop the oldest expectation and compare.
   task automatic check_output(input bit use6);
      int   a, g, f, af, l, e, o, d;
      exp_t x;
      @(posedge w_clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
         return;
      end
      x = sb.pop_front();
      observe(use6, a, g, f, af, l, e, o, d);
      check("w_addr",      a,  x.addr);
      check("gray_w_ptr",  g,  x.gray);
      check("full",        f,  x.full);
      check("almost_full", af, x.afull);
      check("w_level",     l,  x.level);
      check("gray_1bit",   $countones(g ^ prev_gray), x.flips);
`ifdef FIFO_WR_OVF_EN
      check("w_ovf",       o,  x.ovf);
      check("w_drop_cnt",  d,  x.drops);
`endif
      prev_gray = g;
   endtask

   task automatic step(input bit use6, input bit inc, input int rd_bin);
      apply_stimulus(use6, inc, rd_bin);
      check_output(use6);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      model_reset();
      w_rst           = 1'b1;
      if4.w_inc       = 1'b0;
      if4.sync_rd_ptr = '0;
      if6.w_inc       = 1'b0;
      if6.sync_rd_ptr = '0;

      // Reset state of both instances.
      #12;
      check_reset(1'b0, "rst4");
      check_reset(1'b1, "rst6");
      w_rst = 1'b0;
      @(posedge w_clk);
      #1;

      // Fill the 16-deep FIFO with the read pointer parked at 0.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 0);

      // Blocked writes: first one, then a long run to saturate the counter.
      for (int i = 0; i < 301; i++) step(1'b0, 1'b1, 0);

      // One read frees a slot; a write refills it.
      step(1'b0, 1'b0, 1);
      step(1'b0, 1'b1, 1);
      step(1'b0, 1'b0, 2);
      // Read and write in the same cycle keep the level unchanged.
      step(1'b0, 1'b1, 3);
      step(1'b0, 1'b1, 4);

      // Restart and stream 40 writes with the reader two behind.
      w_rst = 1'b1;
      #1;
      model_reset();
      check_reset(1'b0, "rst4b");
      @(posedge w_clk);
      #1;
      w_rst = 1'b0;
      step(1'b0, 1'b1, 0);
      for (int i = 1; i < 40; i++) step(1'b0, 1'b1, (m_w + 31) % 32);

      // Reset asserted mid-burst clears everything without a clock edge.
      if4.w_inc = 1'b1;
      #2;
      w_rst = 1'b1;
      #1;
      check_reset(1'b0, "rst_mid");
      model_reset();
      @(posedge w_clk);
      #1;
      w_rst = 1'b0;
      if4.sync_rd_ptr = '0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0);

      // Wider instance: 64 deep, almost_full at 60.
      w_rst = 1'b1;
      #1;
      model_reset();
      @(posedge w_clk);
      #1;
      w_rst = 1'b0;
      if4.w_inc = 1'b0;
      for (int i = 0; i < 66; i++) step(1'b1, 1'b1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
